// File: rtl/mesh_noc_pkg.sv
// Shared definitions for the mesh NoC router: packet geometry, VC tags and port directions.
package mesh_noc_pkg;

  localparam int DATA_W = 64;
  localparam int VC_BIT = 63;

  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  localparam int DIR_E  = 0;
  localparam int DIR_W  = 1;
  localparam int DIR_N  = 2;
  localparam int DIR_S  = 3;
  localparam int DIR_PE = 4;

  typedef struct packed {
    logic              vc;
    logic [DATA_W-2:0] payload;
  } pkt_t;

  function automatic logic pkt_vc(input pkt_t p);
    return p.vc;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of i_elig at or after i_ptr, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan offsets 0..NUM_REQ-1 from the pointer; the first eligible index wins.
  always_comb begin
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_sel;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      end else begin
        w_sum = w_sum;
      end
      w_sel = w_sum[PTR_W-1:0];
      if (!o_valid && i_elig[w_sel]) begin
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
        o_valid      = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/mesh_output_port_arbiter.sv
// Output-link arbiter: per-VC round-robin grant among input buffers, registered so/do launch.
module mesh_output_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = mesh_noc_pkg::DATA_W,
  parameter int VC_BIT  = mesh_noc_pkg::VC_BIT,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        polarity,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        out_so,
  output logic [DATA_W-1:0]           out_do,
  input  logic                        out_ri,
  output logic [CNT_W-1:0]            pkt_count,
  output logic [1:0]                  busy_vc
);
  import mesh_noc_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 w_serve_vc;
  logic [NUM_REQ-1:0]   w_elig;
  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic [PTR_W-1:0]     w_ptr;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [PTR_W-1:0]     w_next_ptr;
  logic                 w_pick_valid;
  logic                 w_fire;
  logic [DATA_W-1:0]    w_win_data;

  logic [PTR_W-1:0]     r_ptr_even;
  logic [PTR_W-1:0]     r_ptr_odd;
  logic                 r_so;
  logic [DATA_W-1:0]    r_do;
  logic [CNT_W-1:0]     r_cnt;

  assign w_serve_vc = ~polarity;

  // Only the VC tag bit of each head packet decides eligibility and VC occupancy.
  always_comb begin
    w_elig  = '0;
    busy_vc = 2'b00;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req[i] & (req_data[i*DATA_W + VC_BIT] == w_serve_vc);
      if (req[i]) begin
        if (req_data[i*DATA_W + VC_BIT] == VC_ODD) begin
          busy_vc[1] = 1'b1;
        end else begin
          busy_vc[0] = 1'b1;
        end
      end else begin
        busy_vc = busy_vc;
      end
    end
  end

  assign w_ptr = (w_serve_vc == VC_ODD) ? r_ptr_odd : r_ptr_even;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .i_elig  (w_elig),
    .i_ptr   (w_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_fire     = out_ri & w_pick_valid;
  assign gnt        = w_fire ? w_pick_gnt : '0;
  assign w_next_ptr = (w_pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : (w_pick_idx + PTR_W'(1));

  // One-hot grant selects the winner's head packet.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_win_data = req_data[i*DATA_W +: DATA_W];
      end else begin
        w_win_data = w_win_data;
      end
    end
  end

  // Launch register, per-VC pointers and saturating packet counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_so       <= 1'b0;
      r_do       <= '0;
      r_cnt      <= '0;
      r_ptr_even <= '0;
      r_ptr_odd  <= '0;
    end else if (w_fire) begin
      r_so <= 1'b1;
      r_do <= w_win_data;
      if (w_serve_vc == VC_ODD) begin
        r_ptr_odd <= w_next_ptr;
      end else begin
        r_ptr_even <= w_next_ptr;
      end
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end else begin
      r_so <= 1'b0;
    end
  end

  assign out_so    = r_so;
  assign out_do    = r_do;
  assign pkt_count = r_cnt;

endmodule

// File: tb/tb_mesh_output_port_arbiter.sv
// Directed table-driven bench for mesh_output_port_arbiter (4 requesters, 4-bit counter).
module tb_mesh_output_port_arbiter;

  localparam logic [63:0] A0 = 64'h0000_0000_0000_0001;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_0002;
  localparam logic [63:0] A2 = 64'h0000_0000_0000_0003;
  localparam logic [63:0] A3 = 64'h0000_0000_0000_0004;
  localparam logic [63:0] B0 = 64'h8000_0000_0000_00B0;
  localparam logic [63:0] B1 = 64'h8000_0000_0000_00A1;
  localparam logic [63:0] B2 = 64'h8000_0000_0000_00B2;
  localparam logic [63:0] B3 = 64'h8000_0000_0000_00B3;
  localparam logic [255:0] DA   = {A3, A2, A1, A0};
  localparam logic [255:0] DB   = {B3, B2, B1, B0};
  localparam logic [255:0] DMIX = {A3, A2, B1, A0};

  logic         clk = 1'b0;
  logic         reset;
  logic         polarity;
  logic [3:0]   req;
  logic [255:0] req_data;
  logic [3:0]   gnt;
  logic         out_so;
  logic [63:0]  out_do;
  logic         out_ri;
  logic [3:0]   pkt_count;
  logic [1:0]   busy_vc;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic         pol;
    logic         ri;
    logic [3:0]   req;
    logic [255:0] data;
    logic [3:0]   gnt;
    logic         so;
    logic [63:0]  dout;
    logic [3:0]   cnt;
    logic [1:0]   busy;
  } vec_t;

  vec_t vq[$];

  mesh_output_port_arbiter #(
    .NUM_REQ (4),
    .DATA_W  (64),
    .VC_BIT  (63),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_so    (out_so),
    .out_do    (out_do),
    .out_ri    (out_ri),
    .pkt_count (pkt_count),
    .busy_vc   (busy_vc)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic add(input logic pol, input logic ri, input logic [3:0] rq, input logic [255:0] d,
                     input logic [3:0] g, input logic so, input logic [63:0] dout,
                     input logic [3:0] cnt, input logic [1:0] busy);
    vec_t v;
    v = '{pol, ri, rq, d, g, so, dout, cnt, busy};
    vq.push_back(v);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    polarity = v.pol;
    out_ri   = v.ri;
    req      = v.req;
    req_data = v.data;
    #2;
    chk({tag, "_gnt"}, 64'(gnt), 64'(v.gnt));
    chk({tag, "_busy"}, 64'(busy_vc), 64'(v.busy));
    @(posedge clk);
    #1;
    chk({tag, "_so"}, 64'(out_so), 64'(v.so));
    chk({tag, "_do"}, out_do, v.dout);
    chk({tag, "_cnt"}, 64'(pkt_count), 64'(v.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // round robin on VC0 (polarity=1)
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0001, 1'b1, A0, 4'd1,  2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0010, 1'b1, A1, 4'd2,  2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0100, 1'b1, A2, 4'd3,  2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b1000, 1'b1, A3, 4'd4,  2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0001, 1'b1, A0, 4'd5,  2'b01);
    // basic launch on VC1
    add(1'b0, 1'b1, 4'b0010, DMIX, 4'b0010, 1'b1, B1, 4'd6,  2'b10);
    // VC filtering with toggling polarity
    add(1'b1, 1'b1, 4'b0011, DMIX, 4'b0001, 1'b1, A0, 4'd7,  2'b11);
    add(1'b0, 1'b1, 4'b0011, DMIX, 4'b0010, 1'b1, B1, 4'd8,  2'b11);
    add(1'b1, 1'b1, 4'b0011, DMIX, 4'b0001, 1'b1, A0, 4'd9,  2'b11);
    add(1'b0, 1'b1, 4'b0011, DMIX, 4'b0010, 1'b1, B1, 4'd10, 2'b11);
    // pointer independence: VC0 ptr=1, VC1 ptr=2
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0010, 1'b1, A1, 4'd11, 2'b01);
    add(1'b0, 1'b1, 4'b1111, DB,   4'b0100, 1'b1, B2, 4'd12, 2'b10);
    // backpressure
    add(1'b1, 1'b0, 4'b0100, DA,   4'b0000, 1'b0, B2, 4'd12, 2'b01);
    add(1'b1, 1'b0, 4'b0100, DA,   4'b0000, 1'b0, B2, 4'd12, 2'b01);
    add(1'b1, 1'b0, 4'b0100, DA,   4'b0000, 1'b0, B2, 4'd12, 2'b01);
    add(1'b1, 1'b1, 4'b0100, DA,   4'b0100, 1'b1, A2, 4'd13, 2'b01);
    // winner 3 wraps pointer to 0; counter saturates at 15
    add(1'b1, 1'b1, 4'b1111, DA,   4'b1000, 1'b1, A3, 4'd14, 2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0001, 1'b1, A0, 4'd15, 2'b01);
    add(1'b1, 1'b1, 4'b1111, DA,   4'b0010, 1'b1, A1, 4'd15, 2'b01);
    // VC mismatch: no grant, out_do holds
    add(1'b0, 1'b1, 4'b0001, DA,   4'b0000, 1'b0, A1, 4'd15, 2'b01);
    // single requester granted every served cycle
    add(1'b1, 1'b1, 4'b0100, DA,   4'b0100, 1'b1, A2, 4'd15, 2'b01);
    add(1'b1, 1'b1, 4'b0100, DA,   4'b0100, 1'b1, A2, 4'd15, 2'b01);
    // VC1 pointer at 3 wraps to 0
    add(1'b0, 1'b1, 4'b1111, DB,   4'b1000, 1'b1, B3, 4'd15, 2'b10);
    add(1'b0, 1'b1, 4'b1111, DB,   4'b0001, 1'b1, B0, 4'd15, 2'b10);

    reset    = 1'b0;
    polarity = 1'b1;
    out_ri   = 1'b1;
    req      = 4'b1111;
    req_data = DA;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_so", 64'(out_so), 64'd0);
    chk("rst_do", out_do, 64'd0);
    chk("rst_cnt", 64'(pkt_count), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'(4'b0001));
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], $sformatf("v%0d", i));
    end

    // further launches keep the counter pinned at its maximum
    polarity = 1'b1;
    out_ri   = 1'b1;
    req      = 4'b1111;
    req_data = DA;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_cnt", 64'(pkt_count), 64'd15);
    chk("sat_so", 64'(out_so), 64'd1);

    // asynchronous reset in the middle of a launch
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_so", 64'(out_so), 64'd0);
    chk("midrst_cnt", 64'(pkt_count), 64'd0);
    chk("midrst_do", out_do, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    v = '{1'b1, 1'b1, 4'b1111, DA, 4'b0001, 1'b1, A0, 4'd1, 2'b01};
    run_vec(v, "post_rst_vc0");
    v = '{1'b0, 1'b1, 4'b1111, DB, 4'b0001, 1'b1, B0, 4'd2, 2'b10};
    run_vec(v, "post_rst_vc1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_output_port_arbiter.md
Name: mesh_output_port_arbiter

Overview:
- Arbitrates one router output link (E, W, N, S or PE-out) between up to NUM_REQ input-buffer requesters in the 2x2/NxN mesh router.
- Serves the virtual channel selected by the global polarity signal.
- Grants one requester per cycle using a round-robin pointer kept separately for each VC.
- Launches the granted 64-bit packet onto the link through a registered so/do pair, gated by the downstream ready.

Parameters:
- NUM_REQ, 4, number of requesting input buffers (other directions plus PE).
- DATA_W, 64, packet width.
- VC_BIT, 63, packet bit holding the virtual-channel tag (0 = even, 1 = odd).
- CNT_W, 16, width of the saturating launched-packet counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  global even/odd cycle phase; the VC served this cycle is ~polarity.
- req  in  NUM_REQ  per-requester "head packet valid".
- req_data  in  NUM_REQ*DATA_W  head packets; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot, combinational; requester pops its head on the same rising edge.
- out_so  out  1  link send, registered.
- out_do  out  DATA_W  link data, registered.
- out_ri  in  1  downstream buffer ready for the VC currently served.
- pkt_count  out  CNT_W  saturating count of packets launched since reset.
- busy_vc  out  2  bit v set if any requester holds a VC-v packet, combinational.

Behaviour:
- Reset (reset=0, asynchronous):
  - out_so=0, out_do=0, pkt_count=0.
  - Both rr pointers = 0.
  - gnt follows its combinational rule; it is 0 while req=0.
- Served VC: serve_vc = ~polarity, evaluated every cycle.
- Eligibility: elig[i] = req[i] & (req_data[i][VC_BIT] == serve_vc).
- Grant:
  - Condition: out_ri=1 and |elig.
  - Winner: the first eligible index found scanning rr_ptr[serve_vc], rr_ptr+1, ..., wrapping mod NUM_REQ.
  - gnt[winner]=1; every other bit of gnt is 0.
  - If the condition fails, gnt=0.
- Launch, at the rising edge on which gnt is nonzero:
  - out_so <= 1; out_do <= winner's data.
  - rr_ptr[serve_vc] <= (winner+1) mod NUM_REQ.
  - pkt_count <= pkt_count+1, saturating at all-ones.
- No grant: out_so <= 0, out_do holds its last value, pointers unchanged.
- Latency: a packet appears on out_so/out_do exactly 1 cycle after its grant cycle.
  - Throughput is 1 packet per cycle. In practice this is 1 per 2 cycles per VC, since polarity toggles.
- Pointer independence: the rr pointer of the non-served VC is never modified.
- Fairness: with k continuously eligible requesters on one VC, each is granted once per k grants of that VC.
- Boundaries:
  - out_ri=0 while requests are pending: no grant, out_so=0 the next cycle, no pointer movement.
  - Polarity flips mid-stream: eligibility is recomputed combinationally; there is no stale grant.
  - A packet whose VC does not match is never granted in that cycle.
  - Single requester: granted every served cycle; its pointer wraps to (i+1) mod NUM_REQ.
  - Winner is index NUM_REQ-1: pointer wraps to 0.
  - Reset asserted mid-launch: out_so clears immediately, with no glitch-latched data requirement.
  - pkt_count at max stays at max.
- Datapath width: req_data must be exactly NUM_REQ*DATA_W wide. No packet field other than VC_BIT is inspected.

Decomposition:
- Shared package mesh_noc_pkg holds:
  - DATA_W, VC_BIT, VC_EVEN/VC_ODD constants.
  - Direction index constants (DIR_E, DIR_W, DIR_N, DIR_S, DIR_PE).
  - A packet typedef with a vc field.
- One sub-module: rr_priority_picker (NUM_REQ).
  - Inputs: elig vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
  - The top instantiates it once and muxes the pointer by serve_vc.

Test Plan:
- Reset check: hold reset=0 with req=4'b1111 -> out_so=0, out_do=0, pkt_count=0. At release, the first grant goes to index 0 of the served VC.
- Basic launch:
  - Stimulus: polarity=0 (serve VC1); req=4'b0010; req_data[1]=64'h8000_0000_0000_00A1; out_ri=1.
  - Response: gnt=4'b0010 the same cycle; the next cycle out_so=1 and out_do=64'h8000_0000_0000_00A1; rr_ptr[1]=2.
- Round-robin:
  - Stimulus: all 4 requesters hold VC0 packets 64'h0..01, ..02, ..03, ..04; polarity=1 constant; out_ri=1; each requester re-requests after its grant.
  - Response: grants 0,1,2,3,0 on consecutive cycles; pkt_count=5.
- VC filtering:
  - Stimulus: req=4'b0011; req0 holds VC0, req1 holds VC1; polarity toggles each cycle.
  - Response: req1 is granted only when polarity=0, req0 only when polarity=1. Each VC's pointer moves independently.
- Backpressure:
  - Stimulus: out_ri=0 for 3 cycles with req=4'b0100 eligible.
  - Response: gnt=0 and out_so=0 throughout, pointer unchanged.
  - Then out_ri=1 -> gnt=4'b0100 and launch the next cycle.
- Mid-operation reset and saturation:
  - With CNT_W=4, launch 20 packets -> pkt_count=15.
  - Assert reset mid-launch -> out_so=0 and pkt_count=0 immediately; pointers return to 0.
